// File: rtl/mem_master_pkg.sv
// Purpose : shared encodings for the memory access master (size codes, FSM states, lane helpers).
// Latency : n/a (types and pure functions only).
// Backpressure : n/a.
package mem_master_pkg;

  localparam bit DEFAULT_BIG_ENDIAN = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2,
    RESP      = 2'd3
  } state_e;

  // True when the access cannot be served by a single aligned lane of one word.
  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Bit position of the addressed lane's least significant bit within the word.
  // Big-endian puts offset 0 in the top byte, so the lane index is mirrored.
  function automatic logic [4:0] lane_shift(input size_e size, input logic [1:0] off,
                                            input logic big_endian);
    logic [1:0] lane;
    case (size)
      SIZE_BYTE: lane = big_endian ? ~off : off;
      SIZE_HALF: lane = big_endian ? (off ^ 2'b10) : off;  // off is 0 or 2 here
      default:   lane = 2'b00;
    endcase
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Purpose : lane extraction with zero/sign extension for loads, lane merge for partial stores.
// Latency : combinational.
// Backpressure : none.
// Ports   : size/offset/sign_ext select the lane; word_in is the RAM word; store_data is
//           right-justified store data; load_data is the extended lane; merge_data is
//           word_in with only the addressed lane(s) replaced.
module byte_lane_unit
  import mem_master_pkg::*;
#(
  parameter bit BIG_ENDIAN = DEFAULT_BIG_ENDIAN
) (
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lane_mask;

  always_comb begin
    shamt     = lane_shift(size, offset, BIG_ENDIAN);
    lane_b    = word_in[shamt +: 8];
    lane_h    = word_in[shamt +: 16];
    load_data = word_in;
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SIZE_HALF: begin
        load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_data = word_in;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merge_data = (word_in & ~lane_mask) | ((store_data << shamt) & lane_mask);
  end

endmodule

// File: rtl/mem_access_master.sv
// Purpose : turns byte/half/word CPU loads and stores into word-only RAM accesses (RMW for partial stores).
// Latency : word store 1, load 2, partial store 2, error 1 cycle from acceptance to resp_valid.
// Backpressure : req_ready high only in IDLE; one request in flight, no response backpressure.
// Ports   : req_* CPU request (valid/ready), resp_* one-cycle completion pulse with data/error,
//           mem_* word RAM port whose read data arrives one edge after the read strobe.
module mem_access_master
  import mem_master_pkg::*;
#(
  parameter bit BIG_ENDIAN = DEFAULT_BIG_ENDIAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  state_e      state;
  size_e       cap_size;
  logic        cap_signed;
  logic [1:0]  cap_off;
  logic [29:0] cap_word;
  logic [31:0] cap_wdata;

  size_e       req_sz;
  logic        req_err;
  logic        req_is_word;
  logic        in_idle;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_sz      = size_e'(req_size);
  assign req_err     = misaligned(req_sz, req_addr[1:0]);
  assign req_is_word = (req_sz == SIZE_WORD);
  assign in_idle     = (state == IDLE);
  assign req_ready   = in_idle;

  // RAM strobes are driven straight from the request in IDLE so the RAM samples
  // on the acceptance edge itself. Gating with rst_n keeps them quiet while the
  // block is held in reset even if a request is presented.
  always_comb begin
    mem_read      = rst_n & in_idle & req_valid & ~req_err & (~req_write | ~req_is_word);
    mem_write     = rst_n & ((in_idle & req_valid & ~req_err & req_write & req_is_word)
                             | (state == RMW_WRITE));
    mem_address   = in_idle ? {2'b00, req_addr[31:2]} : {2'b00, cap_word};
    mem_writedata = (state == RMW_WRITE) ? merge_data : req_wdata;
  end

  // Lane logic always works on the captured request, so later req_* changes are ignored.
  byte_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .size       (cap_size),
    .offset     (cap_off),
    .sign_ext   (cap_signed),
    .word_in    (mem_readdata),
    .store_data (cap_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_size   <= SIZE_BYTE;
      cap_signed <= 1'b0;
      cap_off    <= 2'b00;
      cap_word   <= '0;
      cap_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_size   <= req_sz;
            cap_signed <= req_signed;
            cap_off    <= req_addr[1:0];
            cap_word   <= req_addr[31:2];
            cap_wdata  <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (req_err || (req_write && req_is_word)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (!req_write) begin
              state <= LOAD_WAIT;
            end else begin
              state <= RMW_WRITE;
            end
          end
        end
        LOAD_WAIT: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_WRITE: begin
          // The merged word is written on this edge; only the completion remains.
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
